// File: rtl/channel_carrier_accumulator.sv
// Carrier wipe-off and code-epoch I/Q integrator for one correlator channel.
// A 3-stage pipeline (LUT, multiply, accumulate/dump) runs at one sample per clock.
module channel_carrier_accumulator #(
    parameter int unsigned SAMPLE_W = 4,
    parameter int unsigned ACC_W    = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [4:0]          phase_addr,
    input  logic                code_chip,
    input  logic                epoch_pulse,
    input  logic                rd_ack,
    output logic [ACC_W-1:0]    acc_i_out,
    output logic [ACC_W-1:0]    acc_q_out,
    output logic                acc_valid,
    output logic                overrun
);

    localparam int unsigned LUT_W  = 4;
    localparam int unsigned PROD_W = SAMPLE_W + LUT_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Quarter-wave cosine with its mirror images folded into one table.
    function automatic logic signed [LUT_W-1:0] cos_lut(input logic [4:0] a);
        logic signed [LUT_W-1:0] c;
        c = '0;
        case (a)
            5'd0, 5'd1, 5'd31:          c = 4'sd7;
            5'd2, 5'd3, 5'd29, 5'd30:   c = 4'sd6;
            5'd4, 5'd28:                c = 4'sd5;
            5'd5, 5'd27:                c = 4'sd4;
            5'd6, 5'd26:                c = 4'sd3;
            5'd7, 5'd25:                c = 4'sd1;
            5'd8, 5'd24:                c = 4'sd0;
            5'd9, 5'd23:                c = -4'sd1;
            5'd10, 5'd22:               c = -4'sd3;
            5'd11, 5'd21:               c = -4'sd4;
            5'd12, 5'd20:               c = -4'sd5;
            5'd13, 5'd14, 5'd18, 5'd19: c = -4'sd6;
            default:                    c = -4'sd7;
        endcase
        return c;
    endfunction

    // Add with clipping; a clipped sum continues from the rail.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0]  a,
                                                        input logic signed [PROD_W-1:0] p);
        logic signed [ACC_W:0] sum;
        sum = (ACC_W+1)'(a) + (ACC_W+1)'(p);
        if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        return $signed(sum[ACC_W-1:0]);
    endfunction

    logic signed [SAMPLE_W-1:0] s1_sample;
    logic signed [LUT_W-1:0]    s1_cos;
    logic signed [LUT_W-1:0]    s1_sin;
    logic                       s1_chip;
    logic                       s1_epoch;

    logic signed [PROD_W-1:0]   mul_i;
    logic signed [PROD_W-1:0]   mul_q;
    logic signed [PROD_W-1:0]   p_i;
    logic signed [PROD_W-1:0]   p_q;

    logic signed [PROD_W-1:0]   s2_p_i;
    logic signed [PROD_W-1:0]   s2_p_q;
    logic                       s2_epoch;

    logic signed [ACC_W-1:0]    acc_i;
    logic signed [ACC_W-1:0]    acc_q;

    // S1: sample, chip, carrier LUT lookup, epoch marker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sample <= '0;
            s1_cos    <= '0;
            s1_sin    <= '0;
            s1_chip   <= 1'b0;
            s1_epoch  <= 1'b0;
        end else begin
            s1_sample <= $signed(sample);
            s1_cos    <= cos_lut(phase_addr);
            s1_sin    <= cos_lut(phase_addr - 5'd8);
            s1_chip   <= code_chip;
            s1_epoch  <= epoch_pulse;
        end
    end

    // Rotation by e^(-j*phi) with the chip sign folded in.
    always_comb begin
        mul_i = PROD_W'(s1_sample) * PROD_W'(s1_cos);
        mul_q = PROD_W'(s1_sample) * PROD_W'(s1_sin);
        p_i   = s1_chip ? mul_i : -mul_i;
        p_q   = s1_chip ? -mul_q : mul_q;
    end

    // S2: registered products
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_p_i   <= '0;
            s2_p_q   <= '0;
            s2_epoch <= 1'b0;
        end else begin
            s2_p_i   <= p_i;
            s2_p_q   <= p_q;
            s2_epoch <= s1_epoch;
        end
    end

    // S3: integrate, dump on epoch, host handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_i     <= '0;
            acc_q     <= '0;
            acc_i_out <= '0;
            acc_q_out <= '0;
            acc_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (s2_epoch) begin
                acc_i_out <= acc_i;
                acc_q_out <= acc_q;
                acc_i     <= ACC_W'(s2_p_i);
                acc_q     <= ACC_W'(s2_p_q);
                acc_valid <= 1'b1;
                if (acc_valid && !rd_ack)
                    overrun <= 1'b1;
            end else begin
                acc_i <= sat_add(acc_i, s2_p_i);
                acc_q <= sat_add(acc_q, s2_p_q);
                if (rd_ack) begin
                    acc_valid <= 1'b0;
                    overrun   <= 1'b0;
                end
            end
        end
    end

endmodule
